// File: rtl/matrix_result_streamer.sv
// Captures the SIZE x SIZE product of the systolic multiplier on done_i and
// streams it row-major over valid/ready, with frame counting and overrun flag.
module matrix_result_streamer #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 3,
   parameter int IDXW  = $clog2(SIZE),
   parameter int FCW   = 8
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                done_i,
   input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mat_i,
   output logic                                out_valid_o,
   input  logic                                out_ready_i,
   output logic [WIDTH-1:0]                    out_data_o,
   output logic [IDXW-1:0]                     out_row_o,
   output logic [IDXW-1:0]                     out_col_o,
   output logic                                out_last_o,
   output logic                                busy_o,
   output logic                                overrun_o,
   output logic [FCW-1:0]                      frame_count_o
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_buf [SIZE][SIZE];
   logic [IDXW-1:0]  r_row;
   logic [IDXW-1:0]  r_col;
   logic             r_overrun;
   logic [FCW-1:0]   r_frame_count;

   logic w_streaming;
   logic w_xfer;
   logic w_last;
   logic w_frame_end;
   logic w_capture;

   assign w_streaming = (r_state == S_STREAM);
   assign w_xfer      = w_streaming && out_ready_i;
   assign w_last      = (r_row == LAST_IDX) && (r_col == LAST_IDX);
   assign w_frame_end = w_xfer && w_last;
   // A new frame is accepted when idle, or exactly as the last element leaves.
   assign w_capture   = done_i && (!w_streaming || w_frame_end);

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      out_valid_o  = 1'b0;
      busy_o       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (done_i) w_next_state = S_STREAM;
         end
         S_STREAM: begin
            out_valid_o = 1'b1;
            busy_o      = 1'b1;
            if (w_frame_end && !done_i) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: the capture buffer is deliberately left out of reset; out_data_o is
   // masked while not valid, so stale contents are never visible.
   always_ff @(posedge clock) begin
      if (w_capture && !reset) begin
         for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
               r_buf[r][c] <= mat_i[r][c];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_row         <= '0;
         r_col         <= '0;
         r_overrun     <= 1'b0;
         r_frame_count <= '0;
      end else begin
         if (w_capture) begin
            r_row <= '0;
            r_col <= '0;
         end else if (w_xfer) begin
            if (r_col == LAST_IDX) begin
               r_col <= '0;
               r_row <= w_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_frame_end) r_frame_count <= r_frame_count + 1'b1;
         if (done_i && w_streaming && !w_frame_end) r_overrun <= 1'b1;
      end
   end

   assign out_data_o    = out_valid_o ? r_buf[r_row][r_col] : '0;
   assign out_row_o     = r_row;
   assign out_col_o     = r_col;
   assign out_last_o    = out_valid_o && w_last;
   assign overrun_o     = r_overrun;
   assign frame_count_o = r_frame_count;

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Sits at the output of the systolic matrix multiplier and drains its SIZE x SIZE product matrix.
- Captures the parallel result array on the multiplier's done pulse.
- Serialises the array element by element, in row-major order, onto a valid/ready stream for a downstream consumer.
- Provides frame counting and overrun detection for results that arrive while a previous frame is still streaming.

Parameters:
- WIDTH, 16, bit width of each result element
- SIZE, 3, matrix order (SIZE x SIZE elements per frame); SIZE >= 2
- IDXW, $clog2(SIZE), width of the row/column index outputs
- FCW, 8, width of the frame counter

Ports:
- clock  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- done_i  input  1  one-cycle pulse from the multiplier: mat_i holds a valid product this cycle
- mat_i  input  [WIDTH-1:0] x [SIZE-1:0][SIZE-1:0]  parallel product matrix, indexed [row][col]
- out_valid_o  output  1  stream element valid
- out_ready_i  input  1  downstream accepts the element
- out_data_o  output  WIDTH  current element, mat[row][col]
- out_row_o  output  IDXW  row index of the current element
- out_col_o  output  IDXW  column index of the current element
- out_last_o  output  1  high with the element [SIZE-1][SIZE-1]
- busy_o  output  1  a captured frame is still being streamed
- overrun_o  output  1  sticky: a done_i pulse was dropped
- frame_count_o  output  FCW  number of fully streamed frames, wraps

Behaviour:
- Reset (reset=1 at a clock edge) has priority over every other event, including mid-frame:
  - state goes to IDLE.
  - out_valid_o=0, out_last_o=0, busy_o=0, overrun_o=0.
  - out_row_o=0, out_col_o=0, out_data_o=0, frame_count_o=0.
  - The capture buffer is not cleared; out_data_o is forced to 0 while out_valid_o=0.
- State machine has two states: IDLE and STREAM.
- IDLE:
  - If done_i=1, load all SIZE*SIZE elements of mat_i into the capture buffer, set row=col=0, and go to STREAM.
  - out_valid_o rises on the next cycle, giving 1-cycle latency from done_i to the first element.
- STREAM:
  - out_valid_o=1 and busy_o=1.
  - out_data_o = buffer[row][col].
  - out_last_o = (row==SIZE-1 && col==SIZE-1).
- Handshake:
  - An element transfers on a cycle with out_valid_o && out_ready_i.
  - Without a transfer, data and indices hold stable; the downstream may stall indefinitely.
- Index advance on transfer:
  - col increments.
  - When col==SIZE-1, col wraps to 0 and row increments.
  - Transfer of the last element ends the frame.
- Frame end:
  - frame_count_o increments by 1 (modulo 2^FCW, 255 -> 0).
  - If done_i=0 on the same cycle, go to IDLE; out_valid_o=0 next cycle.
- Simultaneous done_i with the last transfer:
  - mat_i is captured, row/col reset to 0, and the state stays in STREAM.
  - out_valid_o stays high with no bubble. This is not an overrun.
- done_i=1 in STREAM on any cycle other than the last-element transfer:
  - mat_i is ignored and the buffer is unchanged.
  - overrun_o sets to 1 and stays set until reset.
- Throughput: with out_ready_i held at 1, a frame takes exactly SIZE*SIZE cycles. Back-to-back frames need done_i pulses spaced at least SIZE*SIZE cycles apart.
- Values pass through without arithmetic or width conversion; out_data_o is exactly the captured WIDTH-bit element.
- out_ready_i while out_valid_o=0 has no effect.

Test Plan:
- Basic frame: reset, then done_i pulse with SIZE=3, mat_i[r][c]=10*r+c, out_ready_i=1.
  - out_valid_o rises 1 cycle later.
  - out_data_o sequence is 0,1,2,10,11,12,20,21,22 on consecutive cycles, with out_last_o only on 22.
  - frame_count_o=1 afterwards; then out_valid_o=0.
- Backpressure: same frame with out_ready_i toggling 1,0,0,1,...
  - The element and indices hold during the 0 cycles.
  - The full 9-element order is preserved and there are no duplicates.
- Overrun: done_i pulse with data A; second pulse with data B, with mat_i[0][0]=99, during the 4th element of A.
  - overrun_o=1 and stays 1.
  - All 9 elements of A stream unchanged; B never appears.
- Seamless chaining: done_i with frame B asserted on the exact cycle of A's last transfer.
  - B[0][0] appears on the next cycle with out_valid_o continuously 1.
  - overrun_o stays 0 and frame_count_o=2 after B.
- Reset mid-frame: assert reset during element 5.
  - Next cycle shows out_valid_o=0, busy_o=0, overrun_o=0, frame_count_o=0.
  - A new done_i streams its frame from [0][0].
- Counter wrap: stream 256 frames with FCW=8 -> frame_count_o returns to 0.
